// File: rtl/lif_timestep_scheduler.sv
// -----------------------------------------------------------------------------
// neuron_pkg + lif_timestep_scheduler
//
// Time-multiplexed leaky integrate-and-fire (LIF) neuron array. Each timestep
// runs in two phases:
//   1. ACCUM  - synaptic events are integrated into the per-neuron membranes
//               (saturating add, one event per cycle) until an event with
//               ev_last is accepted.
//   2. UPDATE - neurons are swept in index order, one per cycle. Each neuron
//               is leaked, compared against the latched threshold, and either
//               fires (membrane returns to RESET_VAL) or keeps the leaked value.
// A single DONE cycle then pulses step_done before the block returns to IDLE.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   step_start              request a new timestep (honoured only in IDLE)
//   threshold, leak_factor  timestep parameters, latched on step_start
//   ev_valid/ev_ready       synaptic event handshake
//   ev_idx, ev_weight       event target neuron and unsigned weight
//   ev_last                 final event of the timestep
//   spike_valid, spike_idx  registered spike output
//   spike_count             spikes emitted in the current/last timestep
//   busy                    high whenever not IDLE
//   step_done               one-cycle end-of-timestep pulse
//   dbg_idx, dbg_membrane   combinational membrane read port
// -----------------------------------------------------------------------------

package neuron_pkg;
    typedef logic [31:0] membrane_t;
    typedef logic [31:0] weight_t;
    typedef logic [7:0]  leak_t;

    localparam membrane_t RESET_VAL = '0;
endpackage

module lif_timestep_scheduler
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_start,
    input  logic [31:0]      threshold,
    input  logic [7:0]       leak_factor,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [IDX_W-1:0] ev_idx,
    input  logic [31:0]      ev_weight,
    input  logic             ev_last,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    output logic [15:0]      spike_count,
    output logic             busy,
    output logic             step_done,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [31:0]      dbg_membrane
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_NEURONS - 1);

    // Saturating unsigned add: any carry out pins the membrane at all-ones.
    function automatic membrane_t sat_add(input membrane_t a, input weight_t b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

    // Leak: v - ((v * lf) >> 8) with a full 40-bit product. Since lf <= 255
    // the subtracted term is always below v, so no underflow is possible.
    function automatic membrane_t apply_leak(input membrane_t v, input leak_t lf);
        logic [39:0] prod;
        prod = {8'd0, v} * {32'd0, lf};
        return v - prod[39:8];
    endfunction

    state_t            state;
    state_t            state_next;
    membrane_t         membrane [NUM_NEURONS];
    membrane_t         thr_q;
    leak_t             leak_q;
    logic [IDX_W-1:0]  k;

    logic              ev_accept;
    logic              ev_in_range;
    membrane_t         leaked_p0;
    logic              fire_p0;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (step_start)           state_next = ACCUM;
            ACCUM:   if (ev_accept && ev_last) state_next = UPDATE;
            UPDATE:  if (k == LAST_K)          state_next = DONE;
            DONE:                              state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decode
    // -------------------------------------------------------------------------
    always_comb begin
        ev_ready  = 1'b0;
        busy      = 1'b0;
        step_done = 1'b0;
        case (state)
            IDLE:    ;
            ACCUM:   begin ev_ready = 1'b1; busy = 1'b1; end
            UPDATE:  busy = 1'b1;
            DONE:    begin busy = 1'b1; step_done = 1'b1; end
            default: ;
        endcase
    end

    assign ev_accept   = ev_valid && ev_ready;
    // Out-of-range targets are swallowed; ev_last on them still ends ACCUM.
    assign ev_in_range = (32'(ev_idx) < NUM_NEURONS);

    // -------------------------------------------------------------------------
    // Stage p0: leak + threshold evaluation of neuron k (combinational)
    // -------------------------------------------------------------------------
    always_comb begin
        leaked_p0 = apply_leak(membrane[k], leak_q);
        fire_p0   = (leaked_p0 >= thr_q);
    end

    // -------------------------------------------------------------------------
    // Stage p1: membrane write-back and registered spike output
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                membrane[i] <= RESET_VAL;
            end
            thr_q       <= '0;
            leak_q      <= '0;
            k           <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            spike_count <= '0;
        end else begin
            spike_valid <= 1'b0;
            case (state)
                IDLE: begin
                    k <= '0;
                    if (step_start) begin
                        thr_q       <= threshold;
                        leak_q      <= leak_factor;
                        spike_count <= '0;
                    end
                end
                ACCUM: begin
                    k <= '0;
                    if (ev_accept && ev_in_range) begin
                        membrane[ev_idx] <= sat_add(membrane[ev_idx], ev_weight);
                    end
                end
                UPDATE: begin
                    if (fire_p0) begin
                        membrane[k] <= RESET_VAL;
                        spike_valid <= 1'b1;
                        spike_idx   <= k;
                        if (spike_count != 16'hFFFF) begin
                            spike_count <= spike_count + 16'd1;
                        end
                    end else begin
                        membrane[k] <= leaked_p0;
                    end
                    k <= k + 1'b1;
                end
                default: k <= '0;
            endcase
        end
    end

    // Combinational debug read; indices past the array read as zero.
    always_comb begin
        dbg_membrane = '0;
        if (32'(dbg_idx) < NUM_NEURONS) begin
            dbg_membrane = membrane[dbg_idx];
        end
    end

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
module tb_lif_timestep_scheduler;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          step_start;
    logic [31:0]   threshold;
    logic [7:0]    leak_factor;
    logic          ev_valid;
    logic          ev_ready;
    logic [IW-1:0] ev_idx;
    logic [31:0]   ev_weight;
    logic          ev_last;
    logic          spike_valid;
    logic [IW-1:0] spike_idx;
    logic [15:0]   spike_count;
    logic          busy;
    logic          step_done;
    logic [IW-1:0] dbg_idx;
    logic [31:0]   dbg_membrane;

    always #5 clk = ~clk;

    lif_timestep_scheduler #(.NUM_NEURONS(N), .IDX_W(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .step_start   (step_start),
        .threshold    (threshold),
        .leak_factor  (leak_factor),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_idx       (ev_idx),
        .ev_weight    (ev_weight),
        .ev_last      (ev_last),
        .spike_valid  (spike_valid),
        .spike_idx    (spike_idx),
        .spike_count  (spike_count),
        .busy         (busy),
        .step_done    (step_done),
        .dbg_idx      (dbg_idx),
        .dbg_membrane (dbg_membrane)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: membrane values as plain integers.
    longint unsigned mdl [N];

    typedef struct {
        int              idx;
        longint unsigned w;
    } ev_t;
    ev_t evq[$];

    task automatic check_all_membranes(input string tag);
        for (int j = 0; j < N; j++) begin
            dbg_idx = IW'(j);
            #1;
            n_vec++;
            if (dbg_membrane !== mdl[j][31:0]) begin
                n_err++;
                $display("FAIL %s membrane[%0d]: got %h expected %h", tag, j, dbg_membrane, mdl[j][31:0]);
            end
        end
    endtask

    // Runs one timestep with the events in evq. Called at #1 after a posedge
    // with the DUT idle. Optionally pokes step_start during UPDATE.
    task automatic run_step(input logic [31:0] thr, input logic [7:0] lf,
                            input bit poke_start, input string tag);
        int              exp_sp[$];
        int              got_sp[$];
        int              cyc;
        int              e;
        int              done_cyc;
        bit              done;
        longint unsigned v;
        longint unsigned vl;

        e = evq.size();
        threshold   = thr;
        leak_factor = lf;
        step_start  = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        cyc = 1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_start: got %b expected 1", tag, busy);
        end

        for (int i = 0; i < e; i++) begin
            ev_valid  = 1'b1;
            ev_idx    = IW'(evq[i].idx);
            ev_weight = evq[i].w[31:0];
            ev_last   = (i == e - 1);
            #1;
            n_vec++;
            if (ev_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s ev_ready_accum: got %b expected 1", tag, ev_ready);
            end
            @(posedge clk); #1;
            cyc++;
            v = mdl[evq[i].idx] + evq[i].w;
            if (v > 64'hFFFF_FFFF) v = 64'hFFFF_FFFF;
            mdl[evq[i].idx] = v;
        end
        ev_valid = 1'b0;
        ev_last  = 1'b0;

        // Integrated value of the last target, before the sweep writes it.
        dbg_idx = IW'(evq[e-1].idx);
        #1;
        n_vec++;
        if (dbg_membrane !== mdl[evq[e-1].idx][31:0]) begin
            n_err++;
            $display("FAIL %s accum_value[%0d]: got %h expected %h", tag, evq[e-1].idx,
                     dbg_membrane, mdl[evq[e-1].idx][31:0]);
        end

        for (int kk = 0; kk < N; kk++) begin
            v  = mdl[kk];
            vl = v - (v * lf) / 256;
            if (vl >= thr) begin
                mdl[kk] = 0;
                exp_sp.push_back(kk);
            end else begin
                mdl[kk] = vl;
            end
        end

        done = 1'b0;
        done_cyc = 0;
        for (int t = 0; t < 4 * N; t++) begin
            if (spike_valid === 1'b1) begin
                got_sp.push_back(int'(spike_idx));
                n_vec++;
                if (spike_count !== 16'(got_sp.size())) begin
                    n_err++;
                    $display("FAIL %s spike_count_running: got %0d expected %0d", tag,
                             spike_count, got_sp.size());
                end
            end
            if (step_done === 1'b1) begin
                done = 1'b1;
                done_cyc = cyc;
                break;
            end
            step_start = (poke_start && t == 3);
            @(posedge clk); #1;
            cyc++;
        end
        step_start = 1'b0;

        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s step_done_timeout: got none expected cycle %0d", tag, e + N + 1);
        end else if (done_cyc != e + N + 1) begin
            n_err++;
            $display("FAIL %s step_done_cycle: got %0d expected %0d", tag, done_cyc, e + N + 1);
        end
        n_vec++;
        if (got_sp.size() != exp_sp.size()) begin
            n_err++;
            $display("FAIL %s spike_total: got %0d expected %0d", tag, got_sp.size(), exp_sp.size());
        end else begin
            for (int i = 0; i < exp_sp.size(); i++) begin
                n_vec++;
                if (got_sp[i] != exp_sp[i]) begin
                    n_err++;
                    $display("FAIL %s spike_idx[%0d]: got %0d expected %0d", tag, i, got_sp[i], exp_sp[i]);
                end
            end
        end
        n_vec++;
        if (spike_count !== 16'(exp_sp.size())) begin
            n_err++;
            $display("FAIL %s spike_count_final: got %0d expected %0d", tag, spike_count, exp_sp.size());
        end

        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            n_vec++;
            if (step_done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", tag, step_done, busy);
            end
        end
        check_all_membranes(tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({spike_valid, spike_idx, spike_count, busy, step_done, ev_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got sv=%b si=%0d sc=%0d busy=%b done=%b rdy=%b expected all 0",
                     spike_valid, spike_idx, spike_count, busy, step_done, ev_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) mdl[j] = 0;
        n_vec++;
        if (busy !== 1'b0 || ev_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b rdy=%b expected 0/0", busy, ev_ready);
        end
        check_all_membranes("reset");
    endtask

    task automatic test_single_fire();
        evq.delete();
        evq.push_back('{idx: 3, w: 64'h9000});
        run_step(32'h8000, 8'd0, 1'b0, "single_fire");
        dbg_idx = 4'd3;
        #1;
        n_vec++;
        if (dbg_membrane !== 32'h0 || spike_count !== 16'd1) begin
            n_err++;
            $display("FAIL single_fire_end: got mem=%h cnt=%0d expected 0/1", dbg_membrane, spike_count);
        end
    endtask

    task automatic test_leak_no_fire();
        evq.delete();
        evq.push_back('{idx: 5, w: 64'h8100});
        run_step(32'h8000, 8'h80, 1'b0, "leak_no_fire");
        dbg_idx = 4'd5;
        #1;
        n_vec++;
        if (dbg_membrane !== 32'h4080 || spike_count !== 16'd0) begin
            n_err++;
            $display("FAIL leak_no_fire_end: got mem=%h cnt=%0d expected 4080/0", dbg_membrane, spike_count);
        end
    endtask

    task automatic test_saturation();
        evq.delete();
        evq.push_back('{idx: 0, w: 64'hFFFF_FFF0});
        evq.push_back('{idx: 0, w: 64'h100});
        run_step(32'hFFFF_FFFF, 8'd0, 1'b0, "saturation");
    endtask

    task automatic test_protocol();
        ev_valid  = 1'b1;
        ev_idx    = 4'd2;
        ev_weight = 32'h1234;
        ev_last   = 1'b1;
        #1;
        n_vec++;
        if (ev_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ev_ready: got %b expected 0", ev_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        ev_valid = 1'b0;
        ev_last  = 1'b0;
        dbg_idx  = 4'd2;
        #1;
        n_vec++;
        if (dbg_membrane !== mdl[2][31:0] || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_event_ignored: got mem=%h busy=%b expected %h/0", dbg_membrane, busy, mdl[2][31:0]);
        end
        evq.delete();
        evq.push_back('{idx: 7, w: 64'h100});
        run_step(32'h50, 8'h10, 1'b1, "start_in_update");
    endtask

    task automatic test_random();
        int              ne;
        logic [31:0]     thr;
        logic [7:0]      lf;
        longint unsigned w;
        for (int s = 0; s < 12; s++) begin
            evq.delete();
            ne = $urandom_range(1, 8);
            for (int i = 0; i < ne; i++) begin
                if ($urandom_range(0, 7) == 0) w = 64'(32'hF000_0000 + $urandom_range(0, 32'h0FFF_FFFF));
                else                           w = 64'($urandom_range(0, 32'h0003_0000));
                evq.push_back('{idx: int'($urandom_range(0, N - 1)), w: w});
            end
            thr = (s % 5 == 4) ? 32'h0 : 32'($urandom_range(1, 32'h0004_0000));
            lf  = (s % 4 == 3) ? 8'hFF : 8'($urandom_range(0, 255));
            run_step(thr, lf, 1'b0, $sformatf("random%0d", s));
        end
    endtask

    task automatic test_reset_mid_update();
        int sp_seen;
        int done_seen;
        threshold   = 32'h8000;
        leak_factor = 8'd0;
        step_start  = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        ev_valid  = 1'b1;
        ev_idx    = 4'd8;
        ev_weight = 32'h9000;
        ev_last   = 1'b0;
        @(posedge clk); #1;
        ev_idx    = 4'd9;
        ev_weight = 32'hA000;
        ev_last   = 1'b1;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        ev_last  = 1'b0;
        // Sweep is now evaluating k=0; advance to k=4.
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({spike_valid, spike_count, busy, step_done, ev_ready} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got sv=%b sc=%0d busy=%b done=%b rdy=%b expected all 0",
                     spike_valid, spike_count, busy, step_done, ev_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) mdl[j] = 0;
        sp_seen = 0;
        done_seen = 0;
        for (int t = 0; t < 2 * N; t++) begin
            @(posedge clk); #1;
            if (spike_valid === 1'b1) sp_seen++;
            if (step_done === 1'b1)   done_seen++;
        end
        n_vec++;
        if (sp_seen != 0 || done_seen != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_after: got spikes=%0d done=%0d busy=%b expected 0/0/0", sp_seen, done_seen, busy);
        end
        check_all_membranes("midreset");
    endtask

    initial begin
        rst_n       = 1'b0;
        step_start  = 1'b0;
        threshold   = '0;
        leak_factor = '0;
        ev_valid    = 1'b0;
        ev_idx      = '0;
        ev_weight   = '0;
        ev_last     = 1'b0;
        dbg_idx     = '0;
        for (int j = 0; j < N; j++) mdl[j] = 0;

        test_reset();
        test_single_fire();
        test_leak_no_fire();
        test_saturation();
        test_protocol();
        test_random();
        test_reset_mid_update();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lif_timestep_scheduler.md
LIF_TIMESTEP_SCHEDULER -- requirements
Module: lif_timestep_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 16, giving the count of time-multiplexed LIF neurons (range 2..256).
REQ-002 The block SHALL have parameter IDX_W, default $clog2(NUM_NEURONS), giving the neuron index width.
REQ-003 The block SHALL use membrane_t, weight_t, leak_t and RESET_VAL from neuron_pkg.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port step_start, input, 1 bit: pulse requesting a new timestep.
REQ-007 The block SHALL have port threshold, input, 32 bits: firing threshold, sampled when step_start is accepted.
REQ-008 The block SHALL have port leak_factor, input, 8 bits: leak factor (leak_t), sampled when step_start is accepted.
REQ-009 The block SHALL have port ev_valid, input, 1 bit: synaptic event valid.
REQ-010 The block SHALL have port ev_ready, output, 1 bit: event accepted.
REQ-011 The block SHALL have port ev_idx, input, IDX_W bits: target neuron of the event.
REQ-012 The block SHALL have port ev_weight, input, 32 bits: event weight (weight_t, unsigned).
REQ-013 The block SHALL have port ev_last, input, 1 bit: marks the final event of the timestep.
REQ-014 The block SHALL have port spike_valid, output, 1 bit: spike emitted.
REQ-015 The block SHALL have port spike_idx, output, IDX_W bits: index of the firing neuron.
REQ-016 The block SHALL have port spike_count, output, 16 bits: spikes emitted in the current or last timestep.
REQ-017 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-018 The block SHALL have port step_done, output, 1 bit: one-cycle pulse at the end of the timestep.
REQ-019 The block SHALL have port dbg_idx, input, IDX_W bits, and port dbg_membrane, output, 32 bits: combinational read of membrane[dbg_idx].

Function
REQ-020 Internal storage SHALL be NUM_NEURONS registers of 32 bits each (membrane[]), unsigned.
REQ-021 The FSM SHALL have the states IDLE, ACCUM, UPDATE and DONE.
REQ-022 IDLE->ACCUM SHALL occur on step_start=1; on that transition the block SHALL latch threshold and leak_factor and clear spike_count to 0.
REQ-023 step_start SHALL be ignored in any state other than IDLE.
REQ-024 ev_ready SHALL equal 1 only in ACCUM (a combinational decode of state); an event is accepted on ev_valid & ev_ready.
REQ-025 On each accepted event, membrane[ev_idx] SHALL update to membrane[ev_idx] + ev_weight, saturating at 0xFFFFFFFF; the block SHALL accept one event per cycle, and back-to-back events to the same index SHALL each be applied.
REQ-026 An accepted event with ev_idx >= NUM_NEURONS SHALL be discarded with no membrane change, but ev_last on it still counts.
REQ-027 An accepted event with ev_last=1 SHALL apply its weight and move the FSM ACCUM->UPDATE; a timestep with no real input uses a single event of weight 0 with ev_last=1.
REQ-028 UPDATE SHALL sweep neurons k=0..NUM_NEURONS-1, one per cycle, in index order.
REQ-029 For each neuron k in UPDATE, the block SHALL compute v' = v - ((v * leak_factor) >> 8), using a 40-bit product and truncating the shift.
REQ-030 If v' >= latched threshold (unsigned), then membrane[k] SHALL become RESET_VAL and a spike SHALL fire; otherwise membrane[k] SHALL become v'.
REQ-031 spike_valid and spike_idx SHALL be registered, asserting the cycle after neuron k is evaluated; spike_count SHALL increment in the same cycle and saturate at 0xFFFF.
REQ-032 After k=NUM_NEURONS-1 the FSM SHALL go to DONE for exactly one cycle with step_done=1, then go to IDLE; the spike for neuron NUM_NEURONS-1, if any, coincides with step_done.
REQ-033 Latency: with step_start at cycle 0 and E events accepted back-to-back from cycle 1, step_done SHALL assert at cycle E+NUM_NEURONS+1.
REQ-034 threshold=0 SHALL make every neuron fire; leak_factor=0 SHALL mean no leak; leak_factor=255 SHALL leave v - ((v*255)>>8).

Reset
REQ-035 While rst_n=0, all membrane[] SHALL be RESET_VAL and the FSM SHALL be in IDLE.
REQ-036 While rst_n=0, spike_valid, spike_idx, spike_count, busy, step_done and ev_ready SHALL all be 0, and the latched threshold and leak SHALL be 0.
REQ-037 Reset asserted mid-ACCUM or mid-UPDATE SHALL abort the timestep immediately, with no further spike or step_done.

Verification
REQ-038 Reset check: after reset, outputs SHALL be 0 and dbg_membrane SHALL read 0 for every index.
REQ-039 Single fire: N=16, threshold 0x8000, leak 0, one event idx 3 weight 0x9000 with last -> exactly one spike, spike_idx=3, membrane[3]=0, spike_count=1, step_done at cycle 18.
REQ-040 Leak no-fire: event idx 5 weight 0x8100, leak 0x80 -> no spike, and membrane[5]=0x4080 after step_done.
REQ-041 Saturation: events idx 0 weights 0xFFFFFFF0 then 0x100 (last), leak 0 -> membrane[0] reaches 0xFFFFFFFF, fires, and ends at 0.
REQ-042 Protocol: ev_valid in IDLE sees ev_ready=0 and no membrane change; step_start during UPDATE is ignored, and step_done pulses exactly once.
REQ-043 Reset mid-UPDATE at k=4 with neurons 8 and 9 above threshold -> no spikes afterwards, busy=0, and all membranes are 0.
